color_encoder_8x3: RTL and testbench
====================================

// Module: color_encoder_8x3
// PURPOSE
//   Inverse of the game's 3-to-8 colour/line decoder. Samples 8 one-hot selection
//   lines (l7..l0, from player push-buttons), debounces them and encodes the chosen
//   line back to the 3-bit code {modo,s1,s0}. One code is delivered per press via a
//   valid/ack handshake to the guess-entry logic.
// PARAMETERS
//   DB_CYCLES  4  cycles the synchronised line pattern must stay unchanged before acceptance (>=1)
//   CNT_W      $clog2(DB_CYCLES+1)  debounce counter width (derived, do not override)
// PORTS
//   clk    in   1  single system clock, rising edge
//   rst_n  in   1  reset, asynchronous assert, active-low
//   l7..l0 in   1 each  selection lines, async to clk, active-high
//   ack    in   1  consumer accepted the code; sampled only while valid=1
//   modo   out  1  code bit 2 (MSB)
//   s1     out  1  code bit 1
//   s0     out  1  code bit 0
//   valid  out  1  code is stable and available
//   err    out  1  more than one line was active in the accepted pattern
// BEHAVIOUR
// - Reset: modo=s1=s0=0, valid=0, err=0, FSM=IDLE, counter=0, sync flops=0. Async
//   reset mid-operation aborts any press; no code is emitted for it.
// - Lines pass through a 2-flop synchroniser into an 8-bit bus B (bit i = li).
// - FSM (all outputs registered):
//   IDLE:     B!=0 -> snapshot S<=B, cnt<=0, go DEBOUNCE.
//   DEBOUNCE: B==0 -> IDLE. B!=S -> S<=B, cnt<=0 (restart). B==S and cnt==DB_CYCLES-1
//             -> latch code=index of highest set bit of S, err=(popcount(S)>1),
//             valid<=1, go VALID. Else cnt<=cnt+1.
//   VALID:    code/err/valid held constant regardless of B. ack=1 -> valid<=0, go RELEASE.
//   RELEASE:  B==0 -> IDLE. A held button never produces a second code.
// - Latency: line stable from edge 1 (first sampling edge) -> valid=1 after edge
//   DB_CYCLES+3. ack sampled high -> valid=0 after that same edge.
// - Priority: highest index wins (l7 > ... > l0); err flags multi-press but code still emitted.
// - After ack, modo/s1/s0/err keep the last value until the next VALID entry.
// - ack while valid=0 is ignored. ack held high permanently: each press yields
//   exactly a one-cycle valid pulse.
// CONFIGURATION
//   COLOR_ENC_DEBOUNCE_EN defined: behaviour as above.
//   Not defined: DEBOUNCE state and counter omitted; IDLE with B!=0 goes directly to
//   VALID latching code/err from B; valid=1 after edge 3. DB_CYCLES ignored.
// STRUCTURE
//   Package mm_pkg: NUM_LINES=8, CODE_W=3, state enum {IDLE,DEBOUNCE,VALID,RELEASE},
//   function prio_enc8(8b)->3b, function multi_hot(8b)->1b.
//   Sub-module mm_sync2: parameterised-width 2-flop synchroniser (clk, rst_n).
// TESTING
//   1. Press l5 alone, held 20 cycles, DB_CYCLES=4 -> valid=1 after edge 7,
//      {modo,s1,s0}=3'b101, err=0; ack 2 cycles later -> valid=0 next edge.
//   2. l3 bounces (toggles every cycle for 5 cycles) then holds -> exactly one valid,
//      code 3'b011, timed DB_CYCLES+3 edges from last toggle.
//   3. l6 and l1 pressed together -> code 3'b110, err=1.
//   4. Hold l0 across ack for 30 cycles -> single valid, code 3'b000; release then
//      press l7 -> second valid, code 3'b111.
//   5. rst_n low mid-DEBOUNCE and in VALID -> all outputs 0 immediately (async), no
//      stale code after release of reset.
//   6. Build without COLOR_ENC_DEBOUNCE_EN: press l2 -> valid after edge 3, code 3'b010.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and helpers for the 8-line colour encoder: state encoding,
// code width and the priority/multi-press functions.
package mm_pkg;

  localparam int NUM_LINES = 8;
  localparam int CODE_W    = 3;

  localparam logic [NUM_LINES-1:0] LINES_NONE = 8'h00;
  localparam logic [NUM_LINES-1:0] LINES_ONE  = 8'h01;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    VALID    = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Index of the highest set line; later (higher) indices overwrite lower ones.
  function automatic logic [CODE_W-1:0] prio_enc8(input logic [NUM_LINES-1:0] lines);
    logic [CODE_W-1:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (lines[i]) begin
        idx = CODE_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_hot(input logic [NUM_LINES-1:0] lines);
    return (lines & (lines - LINES_ONE)) != LINES_NONE;
  endfunction

endpackage

// File: rtl/mm_sync2.sv
// Two-flop synchroniser for a bus of asynchronous inputs, cleared by the
// asynchronous active-low reset.
module mm_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= {W{1'b0}};
      sync_q <= {W{1'b0}};
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/color_encoder_8x3.sv
// Debounces eight push-button selection lines and hands one 3-bit code per press
// over a valid/ack handshake. The debounce stage exists only with COLOR_ENC_DEBOUNCE_EN.
module color_encoder_8x3
  import mm_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic l7,
  input  logic l6,
  input  logic l5,
  input  logic l4,
  input  logic l3,
  input  logic l2,
  input  logic l1,
  input  logic l0,
  input  logic ack,
  output logic modo,
  output logic s1,
  output logic s0,
  output logic valid,
  output logic err
);

  logic [NUM_LINES-1:0] lines_s;
  logic [NUM_LINES-1:0] bus_s;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;

  assign lines_s = {l7, l6, l5, l4, l3, l2, l1, l0};

  mm_sync2 #(
    .W(NUM_LINES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (lines_s),
    .q    (bus_s)
  );

`ifdef COLOR_ENC_DEBOUNCE_EN
  localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [NUM_LINES-1:0] snap_q, snap_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
`else
  // DB_CYCLES only shapes the debounce stage, which this build leaves out.
  if (DB_CYCLES < 1) begin : g_db_cycles_unused
  end
`endif

  // Next-state and next-output logic for the press/handshake sequence.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    err_d   = err_q;
    valid_d = valid_q;
`ifdef COLOR_ENC_DEBOUNCE_EN
    snap_d  = snap_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus_s != LINES_NONE) begin
`ifdef COLOR_ENC_DEBOUNCE_EN
          snap_d  = bus_s;
          cnt_d   = CNT_ZERO;
          state_d = DEBOUNCE;
`else
          code_d  = prio_enc8(bus_s);
          err_d   = multi_hot(bus_s);
          valid_d = 1'b1;
          state_d = VALID;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      DEBOUNCE: begin
`ifdef COLOR_ENC_DEBOUNCE_EN
        // Any change of the pattern restarts the stability window.
        if (bus_s == LINES_NONE) begin
          state_d = IDLE;
        end else if (bus_s != snap_q) begin
          snap_d = bus_s;
          cnt_d  = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          code_d  = prio_enc8(snap_q);
          err_d   = multi_hot(snap_q);
          valid_d = 1'b1;
          state_d = VALID;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`else
        state_d = IDLE;
`endif
      end
      VALID: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = RELEASE;
        end else begin
          state_d = VALID;
        end
      end
      RELEASE: begin
        // A held button must be fully released before another press counts.
        if (bus_s == LINES_NONE) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= 3'b000;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef COLOR_ENC_DEBOUNCE_EN
      snap_q  <= LINES_NONE;
      cnt_q   <= CNT_ZERO;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      err_q   <= err_d;
      valid_q <= valid_d;
`ifdef COLOR_ENC_DEBOUNCE_EN
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign modo  = code_q[2];
  assign s1    = code_q[1];
  assign s0    = code_q[0];
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_color_encoder_8x3.sv
// Scoreboard bench for color_encoder_8x3: stimulus queues expected codes and
// arrival edges, an independent monitor checks every valid pulse and handshake.
module tb_color_encoder_8x3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ack;
  logic [7:0] lines;
  logic       modo, s1, s0, valid, err;

`ifdef COLOR_ENC_DEBOUNCE_EN
  localparam int DB_ON = 1;
  localparam int LAT   = 4 + 3;
`else
  localparam int DB_ON = 0;
  localparam int LAT   = 3;
`endif

  typedef struct {
    logic [2:0] code;
    logic       err;
    int         edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   edge_cnt = 0;

  always #5 clk = ~clk;

  color_encoder_8x3 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .l7   (lines[7]),
    .l6   (lines[6]),
    .l5   (lines[5]),
    .l4   (lines[4]),
    .l3   (lines[3]),
    .l2   (lines[2]),
    .l1   (lines[1]),
    .l0   (lines[0]),
    .ack  (ack),
    .modo (modo),
    .s1   (s1),
    .s0   (s0),
    .valid(valid),
    .err  (err)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic expect_code(input logic [2:0] c, input logic e, input int edge_n);
    exp_t x;
    x.code   = c;
    x.err    = e;
    x.edge_n = edge_n;
    exp_q.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_code"}, {modo, s1, s0}, 0);
    check({name, "_valid"}, valid, 0);
    check({name, "_err"}, err, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
    end
  end

  // Monitor: valid rising edges pop the scoreboard; while valid is up the
  // handshake (hold without ack, drop after ack, code kept) is checked.
  initial begin
    logic       prev_valid;
    logic [2:0] prev_code;
    logic       prev_err;
    exp_t       e;
    prev_valid = 1'b0;
    prev_code  = 3'b000;
    prev_err   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        prev_valid = 1'b0;
      end else begin
        if (prev_valid) begin
          if (ack) check("valid_drop_after_ack", valid, 0);
          else     check("valid_hold_without_ack", valid, 1);
          check("code_held", {modo, s1, s0}, prev_code);
          check("err_held", err, prev_err);
        end else if (valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("code", {modo, s1, s0}, e.code);
            check("err", err, e.err);
            check("valid_edge", edge_cnt, e.edge_n);
          end
        end
        prev_valid = (valid === 1'b1);
        prev_code  = {modo, s1, s0};
        prev_err   = err;
      end
    end
  end

  initial begin
    int first;
    rst_n = 1'b1;
    lines = 8'h00;
    ack   = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // l5 alone, held 20 cycles, ack two cycles after valid
    expect_code(3'b101, 1'b0, edge_cnt + LAT);
    lines = 8'h20;
    tick(LAT);
    tick(2);
    ack_pulse();
    tick(20 - LAT - 3);
    lines = 8'h00;
    tick(6);

    // l3 bounces for 5 cycles then holds
    first = edge_cnt + 1;
    expect_code(3'b011, 1'b0, ((DB_ON != 0) ? first + 4 : first) + LAT - 1);
    lines = 8'h08; tick(1);
    lines = 8'h00; tick(1);
    lines = 8'h08; tick(1);
    lines = 8'h00; tick(1);
    lines = 8'h08;
    tick(LAT + 1);
    ack_pulse();
    lines = 8'h00;
    tick(6);

    // l6 and l1 together: priority to l6, multi-press flagged
    expect_code(3'b110, 1'b1, edge_cnt + LAT);
    lines = 8'h42;
    tick(LAT + 1);
    ack_pulse();
    lines = 8'h00;
    tick(6);

    // pattern change while settling: l2, then l4+l2 one cycle later
    first = edge_cnt + 1;
    if (DB_ON != 0) expect_code(3'b100, 1'b1, first + LAT);
    else            expect_code(3'b010, 1'b0, first + LAT - 1);
    lines = 8'h04; tick(1);
    lines = 8'h14;
    tick(LAT + 2);
    ack_pulse();
    lines = 8'h00;
    tick(6);

    // ack held high: l0 held 30 cycles gives one pulse, then l7
    ack = 1'b1;
    expect_code(3'b000, 1'b0, edge_cnt + LAT);
    lines = 8'h01;
    tick(30);
    lines = 8'h00;
    tick(6);
    expect_code(3'b111, 1'b0, edge_cnt + LAT);
    lines = 8'h80;
    tick(LAT + 3);
    lines = 8'h00;
    tick(6);
    ack = 1'b0;
    tick(2);

    // reset while a press is being qualified
    lines = 8'h10;
    tick((DB_ON != 0) ? 4 : 2);
    rst_n = 1'b0;
    #1 check_all_zero("rst_mid_press");
    lines = 8'h00;
    tick(3);
    rst_n = 1'b1;
    tick(LAT + 4);
    check_all_zero("after_rst_mid_press");

    // reset while a code is being offered
    expect_code(3'b110, 1'b0, edge_cnt + LAT);
    lines = 8'h40;
    tick(LAT + 1);
    check("valid_before_rst", valid, 1);
    rst_n = 1'b0;
    #1 check_all_zero("rst_in_valid");
    lines = 8'h00;
    tick(3);
    rst_n = 1'b1;
    tick(LAT + 4);
    check_all_zero("after_rst_in_valid");

    // l2 alone
    expect_code(3'b010, 1'b0, edge_cnt + LAT);
    lines = 8'h04;
    tick(LAT + 1);
    ack_pulse();
    lines = 8'h00;
    tick(6);

    check("pending_expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
